// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the jk_ff_bank flip-flop bank: bank function
// encodings and the legal channel-count range.
package jk_ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_D   = 2'b01,
        MODE_T   = 2'b10,
        MODE_CNT = 2'b11
    } mode_e;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One channel of the bank: reset, set/clear (with conflict), then the
// JK/D/T function or an externally forced counter bit.
module jk_cell
    import jk_ff_bank_pkg::*;
(
    input  logic  Clk,
    input  logic  Rst,
    input  logic  S_n,
    input  logic  R_n,
    input  logic  J,
    input  logic  K,
    input  mode_e Mode,
    input  logic  ForceEn,
    input  logic  ForceVal,
    output logic  Q,
    output logic  Qn,
    output logic  Conflict
);

    logic q_q, q_d;
    logic qn_q, qn_d;
    logic conflict_q, conflict_d;

    always_comb begin
        q_d        = q_q;
        qn_d       = qn_q;
        conflict_d = 1'b0;
        if (Rst) begin
            q_d  = 1'b0;
            qn_d = 1'b1;
        end else if (!S_n && !R_n) begin
            // Both outputs high while set and clear fight, as on the dual part.
            q_d        = 1'b1;
            qn_d       = 1'b1;
            conflict_d = 1'b1;
        end else begin
            if (!S_n) begin
                q_d = 1'b1;
            end else if (!R_n) begin
                q_d = 1'b0;
            end else if (ForceEn) begin
                q_d = ForceVal;
            end else begin
                unique case (Mode)
                    MODE_JK: begin
                        unique case ({J, K})
                            2'b00:   q_d = q_q;
                            2'b01:   q_d = 1'b0;
                            2'b10:   q_d = 1'b1;
                            default: q_d = ~q_q;
                        endcase
                    end
                    MODE_D:  q_d = J;
                    MODE_T:  q_d = q_q ^ J;
                    default: q_d = q_q;
                endcase
            end
            qn_d = ~q_d;
        end
    end

    always_ff @(posedge Clk) begin
        q_q        <= q_d;
        qn_q       <= qn_d;
        conflict_q <= conflict_d;
    end

    assign Q        = q_q;
    assign Qn       = qn_q;
    assign Conflict = conflict_q;

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-channel JK/D/T flip-flop bank with a whole-bank up/down counter mode
// and combinational terminal count.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] S_n,
    input  logic [WIDTH-1:0] R_n,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             CntEn,
    input  logic             CntUp,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Tc,
    output logic [WIDTH-1:0] Conflict
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("jk_ff_bank: WIDTH out of range");
    end

    mode_e            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] count_val;
    logic             force_en;

    assign mode = mode_e'(Mode);

    // Counter wraps modulo 2^WIDTH; set/clear still win per bit inside the cells.
    always_comb begin
        count_val = CntUp ? (q + 1'b1) : (q - 1'b1);
        force_en  = (mode == MODE_CNT) && CntEn;
        Tc        = force_en && (CntUp ? (q == '1) : (q == '0));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .Clk      (Clk),
            .Rst      (Rst),
            .S_n      (S_n[i]),
            .R_n      (R_n[i]),
            .J        (J[i]),
            .K        (K[i]),
            .Mode     (mode),
            .ForceEn  (force_en),
            .ForceVal (count_val[i]),
            .Q        (q[i]),
            .Qn       (Qn[i]),
            .Conflict (Conflict[i])
        );
    end

    assign Q = q;

endmodule
